// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the MEM-stage SRAM controller.
package sram_ctrl_pkg;

  localparam int SRAM_AW = 18;
  localparam int SRAM_DW = 16;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'd1024;

  // IDLE waits for a request, LO/HI each move one 16-bit half, DONE reports completion.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LO   = 2'd1,
    S_HI   = 2'd2,
    S_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/sram_ctrl_if.sv
// CPU request/response and SRAM bus signals of the controller.
import sram_ctrl_pkg::*;

interface sram_ctrl_if;
  logic               wr_en;
  logic               rd_en;
  logic [31:0]        addr;
  logic [31:0]        wdata;
  logic [31:0]        rdata;
  logic               ready;
  logic [SRAM_AW-1:0] sram_addr;
  logic [SRAM_DW-1:0] sram_dq_out;
  logic               sram_dq_oe;
  logic [SRAM_DW-1:0] sram_dq_in;
  logic               sram_we_n;

  // Pipeline side plus the SRAM device model.
  modport master (
    output wr_en, rd_en, addr, wdata, sram_dq_in,
    input  rdata, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
  );

  // The controller itself.
  modport slave (
    input  wr_en, rd_en, addr, wdata, sram_dq_in,
    output rdata, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
  );
endinterface

// File: rtl/sram_ctrl_phase_counter.sv
// Cycle counter for one half-access phase; flags the final cycle of the phase.
module phase_counter #(
  parameter int PHASE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic last
);

  logic [3:0] count;

  // Reload to zero on phase entry, otherwise count while a phase is active.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 4'd0;
    end else if (load) begin
      count <= 4'd0;
    end else if (en) begin
      count <= count + 4'd1;
    end
  end

  assign last = (count == 4'(PHASE_CYCLES - 1));

endmodule

// File: rtl/sram_ctrl.sv
// Splits a 32-bit load/store into two 16-bit SRAM accesses, stalling the pipeline meanwhile.
import sram_ctrl_pkg::*;

module sram_ctrl #(
  parameter logic [31:0] BASE_ADDR    = DEFAULT_BASE_ADDR,
  parameter int          PHASE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  sram_ctrl_if.slave  bus
);

  state_t      state;
  state_t      state_next;
  logic        load;
  logic        phase_en;
  logic        last;
  logic        req;
  logic        op_wr;
  logic [16:0] word_idx;
  logic [31:0] wdata_hold;
  logic [18:0] off;

  assign req      = bus.wr_en | bus.rd_en;
  assign off      = bus.addr[18:0] - BASE_ADDR[18:0];
  assign phase_en = (state == S_LO) || (state == S_HI);

  phase_counter #(.PHASE_CYCLES(PHASE_CYCLES)) u_phase (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .en   (phase_en),
    .last (last)
  );

  // State register; reset abandons any access in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next state; the counter reloads whenever LO or HI is entered.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    case (state)
      S_IDLE: if (req) begin
        state_next = S_LO;
        load       = 1'b1;
      end
      S_LO: if (last) begin
        state_next = S_HI;
        load       = 1'b1;
      end
      S_HI:   if (last) state_next = S_DONE;
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Capture the request at acceptance; a simultaneous read is dropped in favour of the write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_wr      <= 1'b0;
      word_idx   <= 17'd0;
      wdata_hold <= 32'd0;
    end else if (state == S_IDLE && req) begin
      op_wr      <= bus.wr_en;
      word_idx   <= off[18:2];
      wdata_hold <= bus.wdata;
    end
  end

  // Read halves are sampled on the final cycle of each phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.rdata <= 32'd0;
    end else if (!op_wr && last) begin
      if (state == S_LO) bus.rdata[15:0]  <= bus.sram_dq_in;
      if (state == S_HI) bus.rdata[31:16] <= bus.sram_dq_in;
    end
  end

  // Bus outputs; the last write cycle of a phase holds data with the strobe released.
  always_comb begin
    bus.ready       = 1'b0;
    bus.sram_addr   = '0;
    bus.sram_dq_out = '0;
    bus.sram_dq_oe  = 1'b0;
    bus.sram_we_n   = 1'b1;
    case (state)
      S_IDLE: bus.ready = ~req;
      S_LO: begin
        bus.sram_addr = {word_idx, 1'b0};
        if (op_wr) begin
          bus.sram_dq_out = wdata_hold[15:0];
          bus.sram_dq_oe  = 1'b1;
          bus.sram_we_n   = last;
        end
      end
      S_HI: begin
        bus.sram_addr = {word_idx, 1'b1};
        if (op_wr) begin
          bus.sram_dq_out = wdata_hold[31:16];
          bus.sram_dq_oe  = 1'b1;
          bus.sram_we_n   = last;
        end
      end
      S_DONE: bus.ready = 1'b1;
      default: bus.ready = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_sram_ctrl.sv
// Randomized and directed checks of sram_ctrl against a cycle-timeline reference model.
module tb_sram_ctrl;
  localparam int          P    = 2;
  localparam logic [31:0] BASE = 32'd1024;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sram_ctrl_if bus();

  sram_ctrl #(.BASE_ADDR(BASE), .PHASE_CYCLES(P)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int txn_no = 0;

  logic [15:0] sram_mem [int];
  logic [31:0] ref_mem  [int];
  logic [31:0] model_rdata;
  int          ready_hist [$];

  bit          chk_en = 1'b0;
  logic        exp_ready;
  logic        exp_oe;
  logic        exp_we_n;
  logic [17:0] exp_addr;
  logic [15:0] exp_dq;
  bit          exp_rd_chk;

  function automatic logic [15:0] half_rd(input int a);
    return sram_mem.exists(a) ? sram_mem[a] : 16'h0000;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // SRAM device: writes on the strobe, read data presented for the next sampling edge.
  always @(posedge clk) begin
    cyc++;
    if (bus.sram_we_n === 1'b0) sram_mem[int'(bus.sram_addr)] = bus.sram_dq_out;
  end

  always @(negedge clk) bus.sram_dq_in = half_rd(int'(bus.sram_addr));

  // Per-cycle comparison against the expectation of the current cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("ready",     {31'd0, bus.ready},      {31'd0, exp_ready});
      chk("sram_addr", {14'd0, bus.sram_addr},  {14'd0, exp_addr});
      chk("dq_oe",     {31'd0, bus.sram_dq_oe}, {31'd0, exp_oe});
      chk("we_n",      {31'd0, bus.sram_we_n},  {31'd0, exp_we_n});
      chk("dq_out",    {16'd0, bus.sram_dq_out}, {16'd0, exp_dq});
      if (exp_rd_chk) chk("rdata", bus.rdata, model_rdata);
      if (bus.ready && (bus.wr_en || bus.rd_en)) ready_hist.push_back(cyc);
    end
  end

  task automatic set_idle_exp();
    exp_ready  = 1'b1;
    exp_addr   = '0;
    exp_oe     = 1'b0;
    exp_we_n   = 1'b1;
    exp_dq     = '0;
    exp_rd_chk = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      bus.wr_en = 1'b0;
      bus.rd_en = 1'b0;
      set_idle_exp();
      @(posedge clk); #1;
    end
  endtask

  // One access from its first IDLE cycle through DONE; abort_k asserts reset in that cycle.
  task automatic do_txn(input bit w, input bit r, input logic [31:0] a,
                        input logic [31:0] d, input int abort_k);
    int word;
    int idx;
    bit in_ph;
    bit hi;
    logic [31:0] rd_exp;
    word   = int'(((a - BASE) >> 2) & 32'h1ffff);
    rd_exp = ref_mem.exists(word) ? ref_mem[word] : 32'd0;
    txn_no++;
    $display("txn %0d: wr=%0d rd=%0d addr=%0d wdata=%h word=%0d abort=%0d",
             txn_no, w, r, a, d, word, abort_k);
    for (int k = 0; k <= 2*P + 1; k++) begin
      bus.wr_en = w;
      bus.rd_en = r;
      if (k == 0) begin
        bus.addr  = a;
        bus.wdata = d;
      end else begin
        bus.addr  = $urandom;
        bus.wdata = $urandom;
      end
      if (k == abort_k) begin
        rst         = 1'b1;
        bus.wr_en   = 1'b0;
        bus.rd_en   = 1'b0;
        model_rdata = 32'd0;
        set_idle_exp();
        @(posedge clk); #1;
        rst = 1'b0;
        ref_mem[word] = {half_rd(2*word + 1), half_rd(2*word)};
        return;
      end
      in_ph = (k >= 1) && (k <= 2*P);
      hi    = (k > P);
      idx   = hi ? (k - P - 1) : (k - 1);
      exp_ready  = (k == 2*P + 1);
      exp_addr   = in_ph ? 18'(2*word + (hi ? 1 : 0)) : 18'd0;
      exp_oe     = w && in_ph;
      exp_we_n   = !(w && in_ph && (idx != P - 1));
      exp_dq     = (w && in_ph) ? (hi ? d[31:16] : d[15:0]) : 16'h0000;
      exp_rd_chk = (k == 2*P + 1);
      if (k == 2*P + 1) begin
        if (w)       ref_mem[word] = d;
        else if (r)  model_rdata   = rd_exp;
      end
      @(posedge clk); #1;
    end
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    rst            = 1'b1;
    bus.wr_en      = 1'b0;
    bus.rd_en      = 1'b0;
    bus.addr       = '0;
    bus.wdata      = '0;
    bus.sram_dq_in = '0;
    model_rdata    = 32'd0;
    set_idle_exp();
    chk_en = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    idle(2);

    // Directed write then read of the same word.
    do_txn(1'b1, 1'b0, BASE + 32'd8, 32'hDEADBEEF, -1);
    idle(1);
    chk("wr_lo_half", {16'd0, half_rd(4)}, 32'h0000BEEF);
    chk("wr_hi_half", {16'd0, half_rd(5)}, 32'h0000DEAD);
    do_txn(1'b0, 1'b1, 32'd1032, 32'd0, -1);
    idle(1);
    chk("rd_literal", bus.rdata, 32'hDEADBEEF);

    // Back-to-back write/read, ready pulses six cycles apart.
    ready_hist.delete();
    t0 = cyc;
    do_txn(1'b1, 1'b0, 32'd1028, 32'h12345678, -1);
    do_txn(1'b0, 1'b1, 32'd1028, 32'd0, -1);
    idle(1);
    chk("b2b_pulses", ready_hist.size(), 32'd2);
    if (ready_hist.size() == 2) begin
      chk("b2b_first",  ready_hist[0] - t0, 32'd5);
      chk("b2b_second", ready_hist[1] - t0, 32'd11);
    end
    chk("b2b_rdata", bus.rdata, 32'h12345678);

    // Both requests high: write wins, rdata untouched.
    do_txn(1'b1, 1'b1, 32'd1040, 32'hCAFEF00D, -1);
    idle(1);
    chk("prio_rdata", bus.rdata, 32'h12345678);
    chk("prio_lo", {16'd0, half_rd(8)}, 32'h0000F00D);
    chk("prio_hi", {16'd0, half_rd(9)}, 32'h0000CAFE);

    // Reset in cycle 3 of a write, then a normal access.
    do_txn(1'b1, 1'b0, 32'd1036, 32'h55AA33CC, 3);
    idle(1);
    chk("rst_rdata", bus.rdata, 32'd0);
    do_txn(1'b0, 1'b1, 32'd1032, 32'd0, -1);
    idle(1);
    chk("post_rst_rd", bus.rdata, 32'hDEADBEEF);

    // Randomized accesses over a small window, with optional idle gaps.
    for (int i = 0; i < 40; i++) begin
      int op;
      logic [31:0] a;
      op = int'($urandom_range(0, 2));
      a  = BASE + 32'(4 * $urandom_range(0, 31)) + 32'($urandom_range(0, 3));
      do_txn(op != 1, op != 0, a, $urandom, -1);
      idle(int'($urandom_range(0, 2)));
    end
    idle(2);
    chk_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
